// File: rtl/car_sensor_emulator.sv
// car_sensor_emulator: generates the two-beam gate-sensor waveform of one car pass per start command.
// Optional abort/reverse support is compiled in when CAR_EMU_ABORT_EN is defined.
module car_sensor_emulator #(
    parameter int DWELL_W = 16,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               dir,
    input  logic [DWELL_W-1:0] dwell,
`ifdef CAR_EMU_ABORT_EN
    input  logic               abort,
    output logic               aborted,
`endif
    output logic               ready,
    output logic               busy,
    output logic               sensor1,
    output logic               sensor2,
    output logic               done,
    output logic [CNT_W-1:0]   pass_cnt
);

    typedef enum logic [2:0] {S_IDLE, S_PH1, S_PH2, S_PH3, S_GAP} state_t;

    state_t             r_state;
    logic               r_dir;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] r_cnt;
    logic [1:0]         r_sens;
    logic               r_ready;
    logic               r_busy;
    logic               r_done;
    logic [CNT_W-1:0]   r_pass_cnt;
    logic               w_rev;
    logic               w_abort_hit;
    logic [DWELL_W-1:0] w_dwell_eff;

    function automatic logic [1:0] f_pattern(state_t s, logic d);
        case (s)
            S_PH1:   return d ? 2'b01 : 2'b10;
            S_PH2:   return 2'b11;
            S_PH3:   return d ? 2'b10 : 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // Reversing walks back toward the entry side; PH1 leaves through GAP in both directions.
    function automatic state_t f_step(state_t s, logic rev);
        case (s)
            S_PH1:   return rev ? S_GAP : S_PH2;
            S_PH2:   return rev ? S_PH1 : S_PH3;
            S_PH3:   return rev ? S_PH2 : S_GAP;
            default: return S_IDLE;
        endcase
    endfunction

    assign w_dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

`ifdef CAR_EMU_ABORT_EN
    logic r_rev;
    logic r_aborted;
    assign w_rev       = r_rev;
    assign w_abort_hit = abort && !r_rev && (r_state inside {S_PH1, S_PH2, S_PH3});
    assign aborted     = r_aborted;
`else
    assign w_rev       = 1'b0;
    assign w_abort_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_dir      <= 1'b0;
            r_dwell    <= '0;
            r_cnt      <= '0;
            r_sens     <= '0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass_cnt <= '0;
`ifdef CAR_EMU_ABORT_EN
            r_rev      <= 1'b0;
            r_aborted  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef CAR_EMU_ABORT_EN
            r_aborted <= 1'b0;
`endif
            if (r_state == S_IDLE) begin
                if (start) begin
                    r_state <= S_PH1;
                    r_dir   <= dir;
                    r_dwell <= w_dwell_eff;
                    r_cnt   <= w_dwell_eff - DWELL_W'(1);
                    r_sens  <= f_pattern(S_PH1, dir);
                    r_ready <= 1'b0;
                    r_busy  <= 1'b1;
`ifdef CAR_EMU_ABORT_EN
                    r_rev   <= 1'b0;
`endif
                end
            end else if (w_abort_hit) begin
                r_state <= f_step(r_state, 1'b1);
                r_sens  <= f_pattern(f_step(r_state, 1'b1), r_dir);
                r_cnt   <= r_dwell - DWELL_W'(1);
`ifdef CAR_EMU_ABORT_EN
                r_rev   <= 1'b1;
`endif
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - DWELL_W'(1);
            end else begin
                r_cnt   <= r_dwell - DWELL_W'(1);
                r_state <= f_step(r_state, w_rev);
                r_sens  <= f_pattern(f_step(r_state, w_rev), r_dir);
                if (r_state == S_GAP) begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
`ifdef CAR_EMU_ABORT_EN
                    r_aborted <= r_rev;
                    if (!r_rev) begin
`else
                    begin
`endif
                        r_done     <= 1'b1;
                        r_pass_cnt <= r_pass_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign ready    = r_ready;
    assign busy     = r_busy;
    assign sensor1  = r_sens[1];
    assign sensor2  = r_sens[0];
    assign done     = r_done;
    assign pass_cnt = r_pass_cnt;

endmodule

// File: tb/tb_car_sensor_emulator.sv
// Bench for car_sensor_emulator: cycle-queue reference model, directed literal checks, random stimulus.
module tb_car_sensor_emulator;

    localparam int DW = 16;
    localparam int CW = 2;
`ifdef CAR_EMU_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic          dir   = 1'b0;
    logic [DW-1:0] dwell = '0;
    logic          abort = 1'b0;
    logic          ready, busy, sensor1, sensor2, done, dut_aborted;
    logic [CW-1:0] pass_cnt;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    car_sensor_emulator #(.DWELL_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .dir(dir), .dwell(dwell),
`ifdef CAR_EMU_ABORT_EN
        .abort(abort), .aborted(dut_aborted),
`endif
        .ready(ready), .busy(busy), .sensor1(sensor1), .sensor2(sensor2),
        .done(done), .pass_cnt(pass_cnt)
    );
`ifndef CAR_EMU_ABORT_EN
    assign dut_aborted = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: one queue entry per busy cycle ----------------
    typedef struct packed { logic [2:0] ph; logic [1:0] pat; } ent_t;
    ent_t          q[$];
    logic          m_rev  = 1'b0;
    logic          m_dir  = 1'b0;
    logic          m_done = 1'b0;
    logic          m_abt  = 1'b0;
    logic [CW-1:0] m_cnt  = '0;
    int unsigned   m_d    = 1;

    // phase 1..3 = beam phases, 4 = gap
    function automatic logic [1:0] mpat(logic d, int ph);
        if (ph == 1) return d ? 2'b01 : 2'b10;
        if (ph == 2) return 2'b11;
        if (ph == 3) return d ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    task automatic push_phase(input int ph);
        for (int unsigned i = 0; i < m_d; i++) begin
            ent_t e;
            e.ph  = 3'(ph);
            e.pat = mpat(m_dir, ph);
            q.push_back(e);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                q.delete();
                m_rev = 1'b0; m_done = 1'b0; m_abt = 1'b0; m_cnt = '0;
            end else begin
                m_done = 1'b0;
                m_abt  = 1'b0;
                if (q.size() == 0) begin
                    if (start) begin
                        m_dir = dir;
                        m_d   = (dwell == 0) ? 1 : int'(dwell);
                        m_rev = 1'b0;
                        for (int ph = 1; ph <= 4; ph++) push_phase(ph);
                    end
                end else if (ABORT_EN && abort && !m_rev && q[0].ph <= 3) begin
                    int p;
                    p = int'(q[0].ph);
                    q.delete();
                    m_rev = 1'b1;
                    for (int r = p - 1; r >= 1; r--) push_phase(r);
                    push_phase(4);
                end else begin
                    void'(q.pop_front());
                    if (q.size() == 0) begin
                        if (m_rev) m_abt = 1'b1;
                        else begin
                            m_done = 1'b1;
                            m_cnt  = m_cnt + 1'b1;
                        end
                    end
                end
            end
        end
    end

    // every-cycle compare against the model
    initial begin
        logic [7:0] exp_v, act_v;
        forever begin
            @(negedge clk);
            exp_v = {(q.size() != 0) ? q[0].pat : 2'b00, q.size() == 0, q.size() != 0,
                     m_done, m_abt, m_cnt};
            act_v = {sensor1, sensor2, ready, busy, done, dut_aborted, pass_cnt};
            chk("cycle{s1,s2,rdy,busy,done,abt,cnt}", 32'(act_v), 32'(exp_v));
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic d, input int unsigned dw);
        start = 1'b1;
        dir   = d;
        dwell = DW'(dw);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        logic [1:0]    ent3 [4];
        logic [1:0]    lv1  [4];
        logic [1:0]    ab   [8];
        logic [CW-1:0] wrap [5];
        int unsigned   ndone;
        ent3 = '{2'b10, 2'b11, 2'b01, 2'b00};
        lv1  = '{2'b01, 2'b11, 2'b10, 2'b00};
        ab   = '{2'b10, 2'b10, 2'b11, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
        wrap = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_sens",  32'({sensor1, sensor2}), 32'(2'b00));
        chk("rst_ready", 32'(ready), 32'(1'b1));
        chk("rst_busy",  32'(busy), 32'(1'b0));
        chk("rst_done",  32'(done), 32'(1'b0));
        chk("rst_cnt",   32'(pass_cnt), 32'(0));
        @(negedge clk);

        // entering pass, dwell=3
        issue(1'b0, 3);
        for (int k = 1; k <= 13; k++) begin
            if (k <= 12) chk("enter_sens", 32'({sensor1, sensor2}), 32'(ent3[(k - 1) / 3]));
            else begin
                chk("enter_done",  32'(done), 32'(1'b1));
                chk("enter_ready", 32'(ready), 32'(1'b1));
                chk("enter_cnt",   32'(pass_cnt), 32'(1));
            end
            @(negedge clk);
        end

        // leaving pass, dwell=1
        issue(1'b1, 1);
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) chk("leave_sens", 32'({sensor1, sensor2}), 32'(lv1[k - 1]));
            else chk("leave_done", 32'(done), 32'(1'b1));
            @(negedge clk);
        end

        // dwell=0 with start held high: back-to-back passes, period 5 cycles
        start = 1'b1; dir = 1'b0; dwell = '0;
        @(negedge clk);
        for (int k = 1; k <= 15; k++) begin
            if ((k - 1) % 5 < 4) chk("b2b_sens", 32'({sensor1, sensor2}), 32'(ent3[(k - 1) % 5]));
            else chk("b2b_done", 32'(done), 32'(1'b1));
            if (k == 15) start = 1'b0;
            @(negedge clk);
        end
        chk("b2b_cnt", 32'(pass_cnt), 32'(1));

        // start while busy is ignored
        issue(1'b1, 3);
        ndone = 0;
        for (int k = 1; k <= 20; k++) begin
            if (done) ndone++;
            start = (k == 5);
            @(negedge clk);
        end
        chk("busy_start_dones", ndone, 1);
        chk("busy_start_cnt", 32'(pass_cnt), 32'(2));

        // async reset mid-PH2
        issue(1'b0, 3);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_sens",  32'({sensor1, sensor2}), 32'(2'b00));
        chk("midrst_ready", 32'(ready), 32'(1'b1));
        chk("midrst_busy",  32'(busy), 32'(1'b0));
        chk("midrst_cnt",   32'(pass_cnt), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 5; k++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("midrst_nodone", ndone, 0);
        issue(1'b0, 2);
        repeat (8) @(negedge clk);
        chk("post_rst_done", 32'(done), 32'(1'b1));
        chk("post_rst_cnt",  32'(pass_cnt), 32'(1));

        // counter wrap with CNT_W=2
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, 1);
            repeat (4) @(negedge clk);
            chk("wrap_done", 32'(done), 32'(1'b1));
            chk("wrap_cnt",  32'(pass_cnt), 32'(wrap[i]));
        end
        @(negedge clk);

        if (ABORT_EN) begin
            // entering, dwell=2, abort on first PH2 cycle
            issue(1'b0, 2);
            for (int k = 1; k <= 8; k++) begin
                if (k <= 7) chk("abort_sens", 32'({sensor1, sensor2}), 32'(ab[k - 1]));
                else begin
                    chk("abort_pulse", 32'(dut_aborted), 32'(1'b1));
                    chk("abort_nodone", 32'(done), 32'(1'b0));
                    chk("abort_cnt", 32'(pass_cnt), 32'(1));
                end
                abort = (k == 3);
                @(negedge clk);
            end
        end

        // randomized traffic
        for (int n = 0; n < 2500; n++) begin
            start = ($urandom_range(0, 2) == 0);
            dir   = 1'($urandom);
            dwell = DW'($urandom_range(0, 4));
            abort = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        start = 1'b0;
        abort = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
